// File: rtl/fb_pkg.sv
// Shared framebuffer geometry defaults, RGB332 pixel layout and write-sequencer state encoding.
package fb_pkg;

  localparam int FB_W_DEFAULT    = 640;
  localparam int FB_H_DEFAULT    = 480;
  localparam int ADDR_W_DEFAULT  = 19;
  localparam int COORD_W_DEFAULT = 10;

  // RGB332: R [7:5], G [4:2], B [1:0]
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    FLUSH = 2'd3
  } fb_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational (x,y) -> linear framebuffer address plus bounds flag; zero latency, no flow control.
// The 640-wide case uses shift-add (y*512 + y*128); other widths fall back to a constant multiply.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int FB_W    = FB_W_DEFAULT,
  parameter int FB_H    = FB_H_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               in_bounds
);

  localparam logic [COORD_W:0] W_LIM = (COORD_W+1)'(FB_W);
  localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(FB_H);

  logic [ADDR_W-1:0] x_e;
  logic [ADDR_W-1:0] y_e;

  assign x_e = ADDR_W'(x);
  assign y_e = ADDR_W'(y);

  generate
    if (FB_W == 640) begin : g_w640
      assign addr = (y_e << 9) + (y_e << 7) + x_e;
    end else begin : g_wgen
      assign addr = y_e * ADDR_W'(FB_W) + x_e;
    end
  endgenerate

  assign in_bounds = ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);

endmodule

// File: rtl/fb_write_ctrl.sv
// Frame write sequencer: clear pass then rasterizer pixels; writes are registered (1 cycle), px_ready = DRAW.
// Optional FB_DROP_CNT_EN adds a saturating count of clipped pixels on drop_count.
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int FB_W    = FB_W_DEFAULT,
  parameter int FB_H    = FB_H_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         clear_color,
  input  logic               px_valid,
  output logic               px_ready,
  input  logic [COORD_W-1:0] px_x,
  input  logic [COORD_W-1:0] px_y,
  input  logic [7:0]         px_color,
  input  logic               px_last,
  output logic [ADDR_W-1:0]  addr,
  output logic               wen,
  output logic [7:0]         dout,
  output logic               busy,
  output logic               done
`ifdef FB_DROP_CNT_EN
  ,
  output logic [15:0]        drop_count
`endif
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FB_W * FB_H - 1);

  fb_state_t         state;
  fb_state_t         state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  rgb332_t           clr_color;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_in;
  logic              px_hs;

  fb_addr_gen #(
    .FB_W    (FB_W),
    .FB_H    (FB_H),
    .ADDR_W  (ADDR_W),
    .COORD_W (COORD_W)
  ) u_addr_gen (
    .x         (px_x),
    .y         (px_y),
    .addr      (pix_addr),
    .in_bounds (pix_in)
  );

  assign px_ready = (state == DRAW);
  assign busy     = (state != IDLE);
  assign px_hs    = px_valid && px_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == LAST_PIX) state_nxt = DRAW;
      DRAW:    if (px_hs && px_last) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      wen       <= 1'b0;
      dout      <= 8'h00;
      done      <= 1'b0;
      clr_cnt   <= '0;
      clr_color <= '0;
    end else begin
      wen  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            clr_cnt   <= '0;
            clr_color <= clear_color;
          end
        end
        CLEAR: begin
          wen     <= 1'b1;
          addr    <= clr_cnt;
          dout    <= clr_color;
          clr_cnt <= clr_cnt + 1'b1;
        end
        DRAW: begin
          // Clipped pixels are consumed by the handshake but never reach the write port.
          if (px_hs && pix_in) begin
            wen  <= 1'b1;
            addr <= pix_addr;
            dout <= px_color;
          end
        end
        FLUSH:   done <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef FB_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      drop_count <= 16'h0000;
    else if (state == IDLE && start)
      drop_count <= 16'h0000;
    else if (px_hs && !pix_in && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed bench: 4x3 frame controller plus a standalone 640x480 address generator.
module tb_fb_write_ctrl;

  logic        clk_tb = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  clear_color;
  logic        px_valid;
  logic        px_ready;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic [7:0]  px_color;
  logic        px_last;
  logic [18:0] addr;
  logic        wen;
  logic [7:0]  dout;
  logic        busy;
  logic        done;
`ifdef FB_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  logic [9:0]  ag_x;
  logic [9:0]  ag_y;
  logic [18:0] ag_addr;
  logic        ag_in;

  int tests = 0;
  int fails = 0;

  always #5 clk_tb = ~clk_tb;

  fb_write_ctrl #(
    .FB_W    (4),
    .FB_H    (3),
    .ADDR_W  (19),
    .COORD_W (10)
  ) dut (
    .clk         (clk_tb),
    .reset       (reset),
    .start       (start),
    .clear_color (clear_color),
    .px_valid    (px_valid),
    .px_ready    (px_ready),
    .px_x        (px_x),
    .px_y        (px_y),
    .px_color    (px_color),
    .px_last     (px_last),
    .addr        (addr),
    .wen         (wen),
    .dout        (dout),
    .busy        (busy),
    .done        (done)
`ifdef FB_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  fb_addr_gen #(
    .FB_W    (640),
    .FB_H    (480),
    .ADDR_W  (19),
    .COORD_W (10)
  ) ag640 (
    .x         (ag_x),
    .y         (ag_y),
    .addr      (ag_addr),
    .in_bounds (ag_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic set_px(input logic v, input int x, input int y, input logic [7:0] c, input logic l);
    px_valid = v;
    px_x     = 10'(x);
    px_y     = 10'(y);
    px_color = c;
    px_last  = l;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clear_color = 8'h00;
    set_px(1'b0, 0, 0, 8'h00, 1'b0);
    ag_x = 10'd0; ag_y = 10'd0;
    tick(); tick();
    chk("rst_wen", wen, 0);
    chk("rst_addr", addr, 0);
    chk("rst_dout", dout, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", px_ready, 0);

    // Pixel offered in IDLE must be ignored.
    reset = 1'b0;
    set_px(1'b1, 1, 1, 8'hAA, 1'b1);
    tick();
    chk("idle_ready", px_ready, 0);
    tick();
    chk("idle_wen", wen, 0);
    chk("idle_busy", busy, 0);
    set_px(1'b0, 0, 0, 8'h00, 1'b0);

    start = 1'b1; clear_color = 8'h25;
    tick();
    start = 1'b0; clear_color = 8'h00;
    chk("start_busy", busy, 1);
    chk("start_nowrite", wen, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("clr_wen", wen, 1);
      chk("clr_addr", addr, 32'(i));
      chk("clr_dout", dout, 8'h25);
      chk("clr_ready", px_ready, (i == 11) ? 1 : 0);
    end

    set_px(1'b1, 2, 1, 8'hE0, 1'b0);
    tick();
    chk("px21_wen", wen, 1);
    chk("px21_addr", addr, 6);
    chk("px21_dout", dout, 8'hE0);
    set_px(1'b1, 0, 0, 8'h11, 1'b0);
    tick();
    chk("px00_wen", wen, 1);
    chk("px00_addr", addr, 0);
    chk("px00_dout", dout, 8'h11);
    set_px(1'b1, 3, 2, 8'h22, 1'b0);
    tick();
    chk("px32_wen", wen, 1);
    chk("px32_addr", addr, 11);
    chk("px32_dout", dout, 8'h22);
    set_px(1'b1, 4, 0, 8'h33, 1'b0);
    tick();
    chk("clipx_wen", wen, 0);
    chk("clipx_ready", px_ready, 1);
    set_px(1'b1, 0, 3, 8'h44, 1'b0);
    tick();
    chk("clipy_wen", wen, 0);
    set_px(1'b0, 0, 0, 8'h00, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("nohs_wen", wen, 0);
    tick();
    chk("draw_start_busy", busy, 1);
    chk("draw_start_ready", px_ready, 1);
    chk("draw_start_wen", wen, 0);
`ifdef FB_DROP_CNT_EN
    chk("drop_cnt", drop_count, 2);
`endif

    set_px(1'b1, 1, 1, 8'h1C, 1'b1);
    tick();
    set_px(1'b0, 0, 0, 8'h00, 1'b0);
    chk("last_wen", wen, 1);
    chk("last_addr", addr, 5);
    chk("last_dout", dout, 8'h1C);
    chk("last_done", done, 0);
    chk("flush_busy", busy, 1);
    chk("flush_ready", px_ready, 0);
    tick();
    chk("done_pulse", done, 1);
    chk("done_wen", wen, 0);
    chk("done_busy", busy, 0);
    tick();
    chk("done_once", done, 0);
    chk("post_busy", busy, 0);
`ifdef FB_DROP_CNT_EN
    chk("drop_hold", drop_count, 2);
`endif

    // Reset in the middle of a clear pass, then restart from address 0.
    start = 1'b1; clear_color = 8'h5A;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("clr2_addr", addr, 32'(i));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_wen", wen, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", addr, 0);
    start = 1'b1; clear_color = 8'h33;
    tick();
    start = 1'b0;
    chk("restart_busy", busy, 1);
`ifdef FB_DROP_CNT_EN
    chk("drop_clr", drop_count, 0);
`endif
    tick();
    chk("restart_wen", wen, 1);
    chk("restart_addr", addr, 0);
    chk("restart_dout", dout, 8'h33);

    ag_x = 10'd639; ag_y = 10'd479;
    #1;
    chk("ag640_addr", ag_addr, 307199);
    chk("ag640_in", ag_in, 1);
    ag_x = 10'd640; ag_y = 10'd0;
    #1;
    chk("ag640_clipx", ag_in, 0);
    ag_x = 10'd5; ag_y = 10'd480;
    #1;
    chk("ag640_clipy", ag_in, 0);
    ag_x = 10'd3; ag_y = 10'd2;
    #1;
    chk("ag640_mid", ag_addr, 1283);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
